// File: rtl/lcd_bus_responder.sv
// Bus-side model of an ST7032-style character LCD controller: decodes strobed
// instruction/data accesses, tracks busy time and holds a 32-entry DDRAM.
`timescale 1ns/1ps
module lcd_bus_responder #(
    parameter int BUSY_CYC  = 2000,
    parameter int CLEAR_CYC = 76500
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DADOS,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    output logic       Busy,
    output logic       Cmd_Dropped,
    output logic       Disp_On,
    output logic       Cursor_On,
    output logic       Blink_On,
    output logic       Lines2,
    output logic [5:0] Contrast,
    input  logic [4:0] Rd_Addr,
    output logic [7:0] Rd_Char
);
    localparam int MAXC = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          clr_we;

    logic [10:0] sync1, sync2;
    logic        en_s, rs_s, rw_s;
    logic        en_d, rs_d, rw_d;
    logic [7:0]  db_d;
    logic        fall, wr_fall, rd_fall, accept, drop, is_clear;

    logic [6:0]  ac;
    logic [4:0]  idx;
    logic        id, s, is, dl, dh, ion, bon;
    logic [3:0]  osc, fol;
    logic [7:0]  ddram [32];

    assign en_s = sync2[10];
    assign rs_s = sync2[9];
    assign rw_s = sync2[8];

    // Delayed copies hold the bus as it was during the last EN-high cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            en_d  <= 1'b0;
            rs_d  <= 1'b0;
            rw_d  <= 1'b0;
            db_d  <= '0;
        end else begin
            sync1 <= {LCD_EN, LCD_RS, LCD_RW, LCD_DADOS};
            sync2 <= sync1;
            {en_d, rs_d, rw_d, db_d} <= sync2;
        end
    end

    assign fall     = en_d & ~en_s;
    assign wr_fall  = fall & ~rw_d;
    assign rd_fall  = fall & rw_d;
    assign accept   = wr_fall & (state == IDLE);
    assign drop     = wr_fall & (state != IDLE);
    assign is_clear = ~rs_d & (db_d == 8'h01);
    assign idx      = {ac[6], ac[3:0]};

    function automatic logic [6:0] ac_step(
        input logic [6:0] a,
        input logic       inc,
        input logic       two
    );
        logic [3:0] lo;
        logic       wrap;
        lo   = inc ? a[3:0] + 4'd1 : a[3:0] - 4'd1;
        wrap = inc ? (a[3:0] == 4'hF) : (a[3:0] == 4'h0);
        return {two & (a[6] ^ wrap), 2'b00, lo};
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clr_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_n   = '0;
                    state_n = is_clear ? CLEAR : EXEC;
                end
            end
            EXEC: begin
                if (cnt == CW'(BUSY_CYC - 1)) state_n = IDLE;
                else                          cnt_n   = cnt + 1'b1;
            end
            CLEAR: begin
                clr_we = (cnt < CW'(32));
                if (cnt == CW'(CLEAR_CYC - 1)) state_n = IDLE;
                else                           cnt_n   = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ac          <= '0;
            id          <= 1'b1;
            s           <= 1'b0;
            is          <= 1'b0;
            dl          <= 1'b1;
            Lines2      <= 1'b0;
            dh          <= 1'b0;
            Disp_On     <= 1'b0;
            Cursor_On   <= 1'b0;
            Blink_On    <= 1'b0;
            Contrast    <= '0;
            ion         <= 1'b0;
            bon         <= 1'b0;
            osc         <= '0;
            fol         <= '0;
            Cmd_Dropped <= 1'b0;
        end else begin
            Cmd_Dropped <= drop;
            if (accept && rs_d) begin
                ac <= ac_step(ac, id, Lines2);
            end else if (accept) begin
                unique casez (db_d)
                    8'b1???????: ac <= {db_d[6], 2'b00, db_d[3:0]};
                    8'b01??????: begin
                        if (is) begin
                            unique case (db_d[5:4])
                                2'b01: begin
                                    Contrast[5:4] <= db_d[1:0];
                                    ion           <= db_d[3];
                                    bon           <= db_d[2];
                                end
                                2'b10:   fol           <= db_d[3:0];
                                2'b11:   Contrast[3:0] <= db_d[3:0];
                                default: ;
                            endcase
                        end
                    end
                    8'b001?????: begin
                        dl     <= db_d[4];
                        Lines2 <= db_d[3];
                        dh     <= db_d[2];
                        is     <= db_d[0];
                    end
                    8'b0001????: begin
                        if (is)           osc <= db_d[3:0];
                        else if (!db_d[3]) ac <= ac_step(ac, db_d[2], Lines2);
                    end
                    8'b00001???: begin
                        Disp_On   <= db_d[2];
                        Cursor_On <= db_d[1];
                        Blink_On  <= db_d[0];
                    end
                    8'b000001??: begin
                        id <= db_d[1];
                        s  <= db_d[0];
                    end
                    8'b0000001?: ac <= '0;
                    8'b00000001: begin
                        ac <= '0;
                        id <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (rd_fall && rs_d) begin
                ac <= ac_step(ac, id, Lines2);
            end
        end
    end

    // DDRAM deliberately survives Reset.
    always_ff @(posedge Clock) begin
        if (clr_we)            ddram[cnt[4:0]] <= 8'h20;
        else if (accept && rs_d) ddram[idx]    <= db_d;
    end

    assign Rd_Char = ddram[Rd_Addr];
    assign DB_OE   = en_s & rw_s;
    assign DB_OUT  = !DB_OE ? 8'h00 : (rs_s ? ddram[idx] : {Busy, ac});
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Table-driven bench for lcd_bus_responder with a write/read scoreboard.
`timescale 1ns/1ps
module tb_lcd_bus_responder;
    localparam int BC = 60;
    localparam int CC = 200;

    logic       Clock = 0, Reset = 1;
    logic       LCD_EN = 0, LCD_RS = 0, LCD_RW = 0;
    logic [7:0] LCD_DADOS = 0;
    logic [7:0] DB_OUT;
    logic       DB_OE, Busy, Cmd_Dropped;
    logic       Disp_On, Cursor_On, Blink_On, Lines2;
    logic [5:0] Contrast;
    logic [4:0] Rd_Addr = 0;
    logic [7:0] Rd_Char;

    always #5 Clock = ~Clock;

    lcd_bus_responder #(.BUSY_CYC(BC), .CLEAR_CYC(CC)) dut (
        .Clock(Clock), .Reset(Reset), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_DADOS(LCD_DADOS), .DB_OUT(DB_OUT),
        .DB_OE(DB_OE), .Busy(Busy), .Cmd_Dropped(Cmd_Dropped),
        .Disp_On(Disp_On), .Cursor_On(Cursor_On), .Blink_On(Blink_On),
        .Lines2(Lines2), .Contrast(Contrast), .Rd_Addr(Rd_Addr),
        .Rd_Char(Rd_Char)
    );

    typedef struct {
        int         kind;
        logic [7:0] db;
        logic [7:0] exp;
        int         len;
        bit         ccfg;
        bit         l2;
        logic [5:0] con;
        logic [2:0] dsp;
        bit         cch;
        logic [4:0] ra;
        logic [7:0] ch;
    } vec_t;

    int         nchk = 0, nerr = 0, blen = 0;
    bit         mon_en = 0;
    vec_t       wq[$];
    logic [7:0] rq[$];
    vec_t       tbl[$];
    vec_t       mv;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t iw(logic [7:0] d, bit l2, logic [5:0] c,
                                logic [2:0] ds);
        vec_t v;
        v.kind = 0; v.db = d; v.exp = 0; v.len = BC; v.ccfg = 1;
        v.l2 = l2; v.con = c; v.dsp = ds; v.cch = 0; v.ra = 0; v.ch = 0;
        return v;
    endfunction

    function automatic vec_t clr(bit l2, logic [5:0] c, logic [2:0] ds);
        vec_t v;
        v = iw(8'h01, l2, c, ds);
        v.len = CC; v.cch = 1; v.ra = 5'd31; v.ch = 8'h20;
        return v;
    endfunction

    function automatic vec_t dw(logic [7:0] d, logic [4:0] ra, logic [7:0] ch);
        vec_t v;
        v = iw(d, 0, 0, 0);
        v.kind = 1; v.ccfg = 0; v.cch = 1; v.ra = ra; v.ch = ch;
        return v;
    endfunction

    function automatic vec_t rdv(int k, logic [7:0] e);
        vec_t v;
        v = iw(0, 0, 0, 0);
        v.kind = k; v.exp = e; v.ccfg = 0;
        return v;
    endfunction

    // Scoreboard sink: each completed busy period retires one queued write.
    always @(negedge Clock) begin
        if (Reset) begin
            blen = 0;
        end else if (Busy) begin
            blen = blen + 1;
        end else if (blen != 0) begin
            if (mon_en) begin
                if (wq.size() == 0) begin
                    chk("busy_unexpected", wq.size(), 1);
                end else begin
                    mv = wq.pop_front();
                    chk("busy_len", blen, mv.len);
                    if (mv.ccfg) begin
                        chk("lines2", Lines2, mv.l2);
                        chk("contrast", Contrast, mv.con);
                        chk("disp_bits", {Disp_On, Cursor_On, Blink_On}, mv.dsp);
                    end
                    if (mv.cch) chk("rd_char", Rd_Char, mv.ch);
                end
            end
            blen = 0;
        end
    end

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < CC + 100; i++) begin
            @(negedge Clock);
            if (!Busy) break;
        end
        if (i == CC + 100) chk({nm, "_timeout"}, Busy, 0);
    endtask

    task automatic pulse(input bit rs, input bit rw, input logic [7:0] d);
        @(posedge Clock); #1;
        LCD_RS = rs; LCD_RW = rw; LCD_DADOS = d;
        repeat (3) @(posedge Clock);
        #1 LCD_EN = 1;
        repeat (4) @(posedge Clock);
        #1 LCD_EN = 0;
        repeat (4) @(posedge Clock);
        #1 LCD_RW = 0;
    endtask

    task automatic rd(input bit rs, input string nm);
        logic [7:0] e;
        bit         seen;
        fork
            pulse(rs, 1'b1, 8'h00);
            begin
                seen = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge Clock);
                    if (DB_OE) begin
                        seen = 1;
                        break;
                    end
                end
                e = rq.pop_front();
                if (seen) chk(nm, DB_OUT, e);
                else      chk({nm, "_oe"}, DB_OE, 1);
            end
        join
    endtask

    task automatic do_vec(input vec_t v);
        Rd_Addr = v.ra;
        if (v.kind < 2) begin
            wq.push_back(v);
            pulse(v.kind == 1, 1'b0, v.db);
            wait_idle("wr");
            @(posedge Clock);
        end else begin
            rq.push_back(v.exp);
            rd(v.kind == 3, v.kind == 3 ? "data_rd" : "status_rd");
        end
    endtask

    initial begin
        int drops;
        int i;
        repeat (3) @(negedge Clock);
        chk("rst_busy", Busy, 0);
        chk("rst_db_oe", DB_OE, 0);
        chk("rst_db_out", DB_OUT, 0);
        chk("rst_dropped", Cmd_Dropped, 0);
        chk("rst_disp", {Disp_On, Cursor_On, Blink_On}, 0);
        chk("rst_lines2", Lines2, 0);
        chk("rst_contrast", Contrast, 0);
        Reset = 0;
        @(negedge Clock);
        mon_en = 1;

        tbl.push_back(rdv(2, 8'h00));
        tbl.push_back(iw(8'h39, 1, 6'h00, 3'd0));
        tbl.push_back(iw(8'h14, 1, 6'h00, 3'd0));
        tbl.push_back(iw(8'h56, 1, 6'h20, 3'd0));
        tbl.push_back(iw(8'h6D, 1, 6'h20, 3'd0));
        tbl.push_back(iw(8'h70, 1, 6'h20, 3'd0));
        tbl.push_back(iw(8'h0E, 1, 6'h20, 3'd6));
        tbl.push_back(clr(1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h00));
        tbl.push_back(iw(8'h8F, 1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h0F));
        tbl.push_back(dw(8'h41, 5'd15, 8'h41));
        tbl.push_back(dw(8'h42, 5'd16, 8'h42));
        tbl.push_back(rdv(2, 8'h41));
        tbl.push_back(iw(8'h10, 1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h41));
        tbl.push_back(iw(8'h38, 1, 6'h20, 3'd6));
        tbl.push_back(iw(8'h10, 1, 6'h20, 3'd6));
        tbl.push_back(iw(8'h10, 1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h0F));
        tbl.push_back(iw(8'h14, 1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h40));
        tbl.push_back(rdv(3, 8'h42));
        tbl.push_back(rdv(2, 8'h41));
        tbl.push_back(iw(8'h4F, 1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h41));
        tbl.push_back(iw(8'hBF, 1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h0F));
        tbl.push_back(iw(8'h02, 1, 6'h20, 3'd6));
        tbl.push_back(rdv(2, 8'h00));
        tbl.push_back(iw(8'h04, 1, 6'h20, 3'd6));
        tbl.push_back(dw(8'h55, 5'd0, 8'h55));
        tbl.push_back(rdv(2, 8'h4F));
        tbl.push_back(iw(8'h06, 1, 6'h20, 3'd6));
        tbl.push_back(iw(8'h30, 0, 6'h20, 3'd6));
        tbl.push_back(iw(8'h8F, 0, 6'h20, 3'd6));
        tbl.push_back(dw(8'h33, 5'd15, 8'h33));
        tbl.push_back(rdv(2, 8'h00));
        tbl.push_back(iw(8'hC5, 0, 6'h20, 3'd6));
        tbl.push_back(dw(8'h66, 5'd21, 8'h66));
        tbl.push_back(rdv(2, 8'h06));
        tbl.push_back(iw(8'h04, 0, 6'h20, 3'd6));
        tbl.push_back(iw(8'h80, 0, 6'h20, 3'd6));
        tbl.push_back(dw(8'h77, 5'd0, 8'h77));
        tbl.push_back(rdv(2, 8'h0F));
        tbl.push_back(iw(8'h06, 0, 6'h20, 3'd6));
        tbl.push_back(iw(8'h09, 0, 6'h20, 3'd1));

        foreach (tbl[k]) do_vec(tbl[k]);

        // Reads while busy; data read still advances AC.
        wq.push_back(iw(8'h85, 0, 6'h20, 3'd1));
        pulse(1'b0, 1'b0, 8'h85);
        rq.push_back(8'h85);
        rd(1'b0, "busy_status_rd");
        rq.push_back(8'h20);
        rd(1'b1, "busy_data_rd");
        wait_idle("busy_rd");
        @(posedge Clock);
        rq.push_back(8'h06);
        rd(1'b0, "status_after_busy_rd");
        @(negedge Clock);
        chk("db_oe_idle", DB_OE, 0);
        chk("db_out_idle", DB_OUT, 0);

        // Data write during busy must be dropped.
        Rd_Addr = 0;
        wq.push_back(iw(8'h80, 0, 6'h20, 3'd1));
        pulse(1'b0, 1'b0, 8'h80);
        drops = 0;
        fork
            pulse(1'b1, 1'b0, 8'h41);
            begin
                for (i = 0; i < 300; i++) begin
                    @(negedge Clock);
                    if (Cmd_Dropped) drops++;
                    if (!Busy) break;
                end
                if (i == 300) chk("drop_timeout", Busy, 0);
            end
        join
        chk("drop_count", drops, 1);
        @(posedge Clock);
        #1 chk("ddram0_kept", Rd_Char, 8'h77);
        rq.push_back(8'h00);
        rd(1'b0, "ac_after_drop");

        // Reset while idle keeps DDRAM.
        @(negedge Clock);
        Reset = 1;
        @(negedge Clock);
        chk("rst2_lines2", Lines2, 0);
        chk("rst2_contrast", Contrast, 0);
        chk("rst2_disp", {Disp_On, Cursor_On, Blink_On}, 0);
        Reset = 0;
        @(negedge Clock);
        chk("ddram_after_reset", Rd_Char, 8'h77);

        // Reset 100 cycles into a clear aborts it.
        mon_en = 0;
        pulse(1'b0, 1'b0, 8'h01);
        repeat (96) @(negedge Clock);
        chk("busy_in_clear", Busy, 1);
        Reset = 1;
        #1 chk("busy_during_reset", Busy, 0);
        @(negedge Clock);
        Reset = 0;
        @(negedge Clock);
        chk("busy_after_reset", Busy, 0);
        @(posedge Clock);
        mon_en = 1;
        do_vec(iw(8'h0C, 0, 6'h00, 3'd4));
        Rd_Addr = 5'd31;
        #1 chk("clear_partial_31", Rd_Char, 8'h20);
        do_vec(rdv(2, 8'h00));

        // Full clear: every entry must read back as space.
        do_vec(clr(0, 6'h00, 3'd4));
        for (int a = 0; a < 32; a++) begin
            Rd_Addr = 5'(a);
            #1 chk("clear_all", Rd_Char, 8'h20);
        end
        do_vec(rdv(2, 8'h00));

        repeat (4) @(negedge Clock);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
